// File: rtl/mdu_pkg.sv
// Shared MDU opcode encoding and the opcode-class helpers used by the decoder and the MDU.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    function automatic logic is_arith(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mul(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers; results are computed at start
// into shadow registers and committed after a fixed busy window.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    mdu_op_e     op, op_q;
    logic        accept, done;
    logic        bz_q;
    logic [31:0] hi_tmp, lo_tmp;
    logic [31:0] res_hi, res_lo;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;
    logic        [31:0] b_u, quot_u, rem_u;
    logic               b_zero, ovf;

    assign op   = mdu_op_e'(mdu_op);
    assign busy = (state == RUN);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_arith(op)) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                    cnt_nx   = is_mul(op) ? MULT_CYCLES[3:0] : DIV_CYCLES[3:0];
                end
            end
            RUN: begin
                if (cnt == 4'd1) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Zero divisor and MIN/-1 both divide by 1: the former is never committed, the latter
    // then naturally yields quotient MIN and remainder 0.
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'b0, A} * {32'b0, B};
        b_zero = (B == '0);
        ovf    = (A == 32'h8000_0000) && (B == '1);
        a_s    = A;
        b_s    = (b_zero || ovf) ? 32'sd1 : B;
        b_u    = b_zero ? 32'd1 : B;
        quot_s = a_s / b_s;
        rem_s  = a_s % b_s;
        quot_u = A / b_u;
        rem_u  = A % b_u;
        res_hi = '0;
        res_lo = '0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV:   begin res_hi = rem_s; res_lo = quot_s; end
            MDU_DIVU:  begin res_hi = rem_u; res_lo = quot_u; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= MDU_NONE;
            bz_q   <= 1'b0;
            hi_tmp <= '0;
            lo_tmp <= '0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                op_q   <= op;
                bz_q   <= b_zero;
                hi_tmp <= res_hi;
                lo_tmp <= res_lo;
            end
            if (done) begin
                if (!(bz_q && !is_mul(op_q))) begin
                    HI <= hi_tmp;
                    LO <= lo_tmp;
                end
            end else if (state == IDLE) begin
                if (op == MDU_MTHI) HI <= A;
                if (op == MDU_MTLO) LO <= A;
            end
        end
    end

    always_comb begin
        mdu_out = '0;
        if (op == MDU_MFHI)      mdu_out = HI;
        else if (op == MDU_MFLO) mdu_out = LO;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: busy window length, HI/LO results, move/readout and reset behaviour.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, busy;
    logic [3:0]  mdu_op;
    logic [31:0] A, B, HI, LO, mdu_out;
    int          checks = 0;
    int          failures = 0;
    int          cyc;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; mdu_op = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; mdu_op = MDU_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        mdu_op = op; A = val;
        @(negedge clk);
        mdu_op = MDU_NONE;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mdu_op = MDU_NONE; A = '0; B = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        @(negedge clk) reset = 1'b0;

        move_to(MDU_MTHI, 32'hAAAA_0001);
        move_to(MDU_MTLO, 32'h5555_0002);
        check("mthi_pre", HI, 32'hAAAA_0001);
        check("mtlo_pre", LO, 32'h5555_0002);

        // async reset on cycle 3 of a mult
        issue(MDU_MULT, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        check("run_c3_busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_busy", {31'b0, busy}, 32'd0);
        check("async_hi", HI, 32'h0);
        check("async_lo", LO, 32'h0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("discard_busy", {31'b0, busy}, 32'd0);
        check("discard_lo", LO, 32'h0);

        issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cyc);
        check("mult_cycles", cyc, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cyc);
        check("multu_cycles", cyc, 32'd5);
        check("multu_hi", HI, 32'h1);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        check("div_cycles", cyc, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        issue(MDU_DIVU, 32'd7, 32'd2);
        wait_idle(cyc);
        check("divu_cycles", cyc, 32'd10);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        move_to(MDU_MTHI, 32'h1234);
        mdu_op = MDU_MFHI; #1;
        check("mfhi_out", mdu_out, 32'h1234);
        mdu_op = MDU_MFLO; #1;
        check("mflo_out", mdu_out, 32'd3);
        mdu_op = MDU_NONE; #1;
        check("none_out", mdu_out, 32'd0);

        // mtlo and mflo while busy
        issue(MDU_MULT, 32'd3, 32'd4);
        mdu_op = MDU_MTLO; A = 32'hDEAD;
        @(negedge clk);
        check("mtlo_busy_lo", LO, 32'd3);
        mdu_op = MDU_MFLO; #1;
        check("mflo_busy_old", mdu_out, 32'd3);
        mdu_op = MDU_NONE;
        wait_idle(cyc);
        check("mult2_rem_cycles", cyc, 32'd4);
        check("mult2_hi", HI, 32'd0);
        check("mult2_lo", LO, 32'd12);

        move_to(MDU_MTHI, 32'd5);
        move_to(MDU_MTLO, 32'd6);
        issue(MDU_DIV, 32'd100, 32'd0);
        wait_idle(cyc);
        check("div0_cycles", cyc, 32'd10);
        check("div0_hi", HI, 32'd5);
        check("div0_lo", LO, 32'd6);

        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        check("divovf_cycles", cyc, 32'd10);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'h0);

        // start with a non-arithmetic op is ignored
        @(negedge clk) begin start = 1'b1; mdu_op = MDU_MFHI; end
        @(negedge clk) begin start = 1'b0; mdu_op = MDU_NONE; end
        check("badop_busy", {31'b0, busy}, 32'd0);
        check("badop_hi", HI, 32'h0);

        // start while busy ignored, back-to-back mult, operand changes during run
        issue(MDU_MULT, 32'd3, 32'd5);
        @(negedge clk);
        start = 1'b1; mdu_op = MDU_DIVU; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; mdu_op = MDU_NONE; A = 32'hFFFF; B = 32'hFFFF;
        wait_idle(cyc);
        check("b2b1_rem_cycles", cyc, 32'd3);
        check("b2b1_lo", LO, 32'd15);
        check("b2b1_hi", HI, 32'd0);
        start = 1'b1; mdu_op = MDU_MULT; A = 32'd6; B = 32'd7;
        @(negedge clk);
        start = 1'b0; mdu_op = MDU_NONE; A = 32'h1234; B = 32'd99;
        check("b2b2_busy", {31'b0, busy}, 32'd1);
        wait_idle(cyc);
        check("b2b2_cycles", cyc, 32'd5);
        check("b2b2_lo", LO, 32'd42);
        check("b2b2_hi", HI, 32'd0);
        @(negedge clk);
        check("no_queue_busy", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
